// File: rtl/sram_cache_ctrl.sv
// -----------------------------------------------------------------------------
// sram_cache_ctrl
//
// Two-way set-associative read cache between the EXE/MEM pipeline register and
// a 16-bit asynchronous SRAM.
// - Loads that hit return data combinationally in the same cycle.
// - Load misses fill a whole 64-bit line as four halfword reads.
// - Stores are write-through with no write-allocate. On a store hit the cached
//   word is updated as well.
// - `ready` low freezes the pipeline while the SRAM is busy.
//
// Parameters
//   SETS        sets per way (power of two, 2..256)
//   WAIT_CYCLES cycles per SRAM halfword access (>= 2)
//   BASE_ADDR   CPU byte address that maps to SRAM halfword 0
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   mem_r_en, mem_w_en            load / store request, held until ready=1
//   address[31:0], wdata[31:0]    CPU byte address and store data
//   rdata[31:0], ready            load data and pipeline-advance strobe
//   SRAM_DQ[15:0]                 bidirectional data bus (driven only on writes)
//   SRAM_ADDR[17:0], SRAM_WE_N    halfword address and write strobe
//   SRAM_UB_N/LB_N/CE_N/OE_N      tied active (0)
// -----------------------------------------------------------------------------
module sram_cache_ctrl #(
  parameter int SETS        = 64,
  parameter int WAIT_CYCLES = 2,
  parameter int BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 16 - IDX_W;
  localparam int CW    = $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST_CYC = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

  // ---------------------------------------------------------------------------
  // Address decomposition (modulo arithmetic relative to BASE_ADDR)
  // ---------------------------------------------------------------------------
  logic [31:0]      rel_addr;
  logic [16:0]      word;
  logic             req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             unused_addr_bits;

  assign rel_addr = address - 32'(BASE_ADDR);
  assign word     = rel_addr[18:2];
  assign req_off  = word[0];
  assign req_idx  = word[IDX_W:1];
  assign req_tag  = word[16:IDX_W+1];
  assign unused_addr_bits = ^{rel_addr[31:19], rel_addr[1:0]};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                     state_q;
  logic [1:0]                 win_q;
  logic [CW-1:0]              cyc_q;
  logic [SETS-1:0][1:0]       valid_q;
  logic [SETS-1:0]            lru_q;
  logic                       victim_q;
  logic                       wr_hit_q;
  logic                       wr_way_q;
  logic [47:0]                fill_buf_q;
  logic [17:0]                sram_addr_q;
  logic                       we_n_q;
  logic                       dq_oe_q;
  logic [15:0]                dq_out_q;

  logic          last_cyc;
  logic [CW-1:0] cyc_inc;

  assign last_cyc = (cyc_q == LAST_CYC);
  assign cyc_inc  = cyc_q + 1'b1;

  // ---------------------------------------------------------------------------
  // Way storage: tag + 64-bit line per set, combinational read port for
  // zero-latency hits, single write port shared by fill and store-hit.
  // ---------------------------------------------------------------------------
  logic [1:0][63:0]      way_line;
  logic [1:0][TAG_W-1:0] way_tag;
  logic [1:0]            way_hit;
  logic [1:0]            fill_we;
  logic [1:0]            word_we;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      logic [63:0]      data_mem [SETS];
      logic [TAG_W-1:0] tag_mem  [SETS];

      // The final halfword of a fill comes straight off the bus so the line
      // is written complete in one go; a partial line never reaches storage.
      assign fill_we[gi] = !rst && (state_q == S_FILL) && last_cyc &&
                           (win_q == 2'd3) && (victim_q == 1'(gi));
      assign word_we[gi] = !rst && (state_q == S_WRITE) && last_cyc &&
                           (win_q == 2'd1) && wr_hit_q && (wr_way_q == 1'(gi));

      always_ff @(posedge clk) begin
        if (fill_we[gi]) begin
          data_mem[req_idx] <= {SRAM_DQ, fill_buf_q};
          tag_mem[req_idx]  <= req_tag;
        end else if (word_we[gi]) begin
          if (req_off) begin
            data_mem[req_idx][63:32] <= wdata;
          end else begin
            data_mem[req_idx][31:0] <= wdata;
          end
        end
      end

      assign way_line[gi] = data_mem[req_idx];
      assign way_tag[gi]  = tag_mem[req_idx];
      assign way_hit[gi]  = valid_q[req_idx][gi] && (way_tag[gi] == req_tag);
    end
  endgenerate

  logic hit_any;
  logic hit_way;
  logic victim_sel;

  assign hit_any = |way_hit;
  assign hit_way = way_hit[1];

  // Prefer an empty way; only fall back to LRU when the set is full.
  always_comb begin
    victim_sel = lru_q[req_idx];
    if (!valid_q[req_idx][0]) begin
      victim_sel = 1'b0;
    end else if (!valid_q[req_idx][1]) begin
      victim_sel = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      win_q       <= 2'd0;
      cyc_q       <= '0;
      valid_q     <= '0;
      lru_q       <= '0;
      victim_q    <= 1'b0;
      wr_hit_q    <= 1'b0;
      wr_way_q    <= 1'b0;
      fill_buf_q  <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          win_q <= 2'd0;
          cyc_q <= '0;
          if (mem_w_en) begin
            // Hit status is captured now; the address is stable until DONE.
            state_q     <= S_WRITE;
            wr_hit_q    <= hit_any;
            wr_way_q    <= hit_way;
            sram_addr_q <= {word, 1'b0};
            dq_out_q    <= wdata[15:0];
            dq_oe_q     <= 1'b1;
            we_n_q      <= 1'b0;
          end else if (mem_r_en) begin
            if (hit_any) begin
              lru_q[req_idx] <= ~hit_way;
            end else begin
              state_q     <= S_FILL;
              victim_q    <= victim_sel;
              sram_addr_q <= {word[16:1], 2'b00};
              we_n_q      <= 1'b1;
            end
          end
        end

        S_FILL: begin
          if (last_cyc) begin
            cyc_q <= '0;
            case (win_q)
              2'd0:    fill_buf_q[15:0]  <= SRAM_DQ;
              2'd1:    fill_buf_q[31:16] <= SRAM_DQ;
              2'd2:    fill_buf_q[47:32] <= SRAM_DQ;
              default: ;
            endcase
            if (win_q == 2'd3) begin
              valid_q[req_idx][victim_q] <= 1'b1;
              lru_q[req_idx]             <= ~victim_q;
              state_q                    <= S_DONE;
            end else begin
              win_q       <= win_q + 2'd1;
              sram_addr_q <= {word[16:1], win_q + 2'd1};
            end
          end else begin
            cyc_q <= cyc_inc;
          end
        end

        S_WRITE: begin
          if (last_cyc) begin
            // WE_N is high in this cycle, so the address may move now.
            cyc_q <= '0;
            if (win_q == 2'd0) begin
              win_q       <= 2'd1;
              sram_addr_q <= {word, 1'b1};
              dq_out_q    <= wdata[31:16];
              we_n_q      <= 1'b0;
            end else begin
              state_q <= S_DONE;
              dq_oe_q <= 1'b0;
              we_n_q  <= 1'b1;
            end
          end else begin
            cyc_q  <= cyc_inc;
            // Release the strobe for the final cycle of the window.
            we_n_q <= (cyc_inc == LAST_CYC);
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          win_q   <= 2'd0;
          cyc_q   <= '0;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ready = 1'b0;
    case (state_q)
      S_IDLE:  ready = !mem_w_en && !(mem_r_en && !hit_any);
      S_DONE:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // In DONE the requested line now sits in the victim way just filled.
  logic        sel_way;
  logic [63:0] sel_line;

  assign sel_way  = (state_q == S_DONE) ? victim_q : hit_way;
  assign sel_line = way_line[sel_way];
  assign rdata    = req_off ? sel_line[63:32] : sel_line[31:0];

  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_cache_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for sram_cache_ctrl.
// The SRAM model holds 4096 halfwords, indexed by SRAM_ADDR[11:0]. Each
// location starts as 16'hA000 + location. Writes are captured while WE_N is
// low. Expected values in the vector table are derived by hand from that
// initial content.
// -----------------------------------------------------------------------------
module tb_sram_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  tri   [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic        sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

  always #5 clk = ~clk;

  sram_cache_ctrl #(.SETS(64), .WAIT_CYCLES(2), .BASE_ADDR(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_r_en  (mem_r_en),
    .mem_w_en  (mem_w_en),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (sram_we_n),
    .SRAM_UB_N (sram_ub_n),
    .SRAM_LB_N (sram_lb_n),
    .SRAM_CE_N (sram_ce_n),
    .SRAM_OE_N (sram_oe_n)
  );

  // SRAM model
  logic [15:0] sram_mem [4096];
  logic        mem_init = 1'b1;
  logic        tb_drive = 1'b1;

  assign sram_dq = tb_drive ? sram_mem[sram_addr[11:0]] : 16'hzzzz;

  always @(negedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) sram_mem[i] <= 16'hA000 + 16'(i);
    end else if (!sram_we_n) begin
      sram_mem[sram_addr[11:0]] <= sram_dq;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  // Per-cycle trace of the stalled cycles of the last request.
  logic [17:0] trace_addr [32];
  logic        trace_we   [32];
  logic [15:0] trace_dq   [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that completes
  // the request, with requests deasserted.
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int low);
    bit done;
    low  = 0;
    done = 0;
    rd   = '0;
    if (wr) tb_drive = 1'b0;
    address  = addr;
    wdata    = wd;
    mem_w_en = wr;
    mem_r_en = !wr;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (ready) begin
        rd   = rdata;
        done = 1;
        break;
      end
      if (low < 32) begin
        trace_addr[low] = sram_addr;
        trace_we[low]   = sram_we_n;
        trace_dq[low]   = sram_dq;
      end
      low++;
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: ready never rose for addr %h", addr);
    end
    @(posedge clk);
    #1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    tb_drive = 1'b1;
    $display("txn %s addr=%h wdata=%h rdata=%h stall=%0d", wr ? "ST" : "LD", addr, wd, rd, low);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    mem_init = 1'b1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    mem_init = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_low;
  } vec_t;

  vec_t vt [21];

  initial begin
    logic [31:0] rd;
    int          low;
    logic [17:0] exp_fill_addr [9];
    logic [17:0] exp_wr_addr   [4];
    logic        exp_wr_we     [4];
    bit          all_we_high;

    vt[0]  = '{1'b0, 32'h0000_0400, 32'h0, 32'hA001_A000, 9};
    vt[1]  = '{1'b0, 32'h0000_0400, 32'h0, 32'hA001_A000, 0};
    vt[2]  = '{1'b0, 32'h0000_0404, 32'h0, 32'hA003_A002, 0};
    vt[3]  = '{1'b1, 32'h0000_0400, 32'h1234_5678, 32'h0, 5};
    vt[4]  = '{1'b0, 32'h0000_0400, 32'h0, 32'h1234_5678, 0};
    vt[5]  = '{1'b0, 32'h0000_0404, 32'h0, 32'hA003_A002, 0};
    vt[6]  = '{1'b1, 32'h0000_0800, 32'hCAFE_F00D, 32'h0, 5};
    vt[7]  = '{1'b0, 32'h0000_0800, 32'h0, 32'hCAFE_F00D, 9};
    vt[8]  = '{1'b0, 32'h0000_0804, 32'h0, 32'hA203_A202, 0};
    vt[9]  = '{1'b0, 32'h0000_0400, 32'h0, 32'h1234_5678, 0};
    vt[10] = '{1'b0, 32'h0000_0600, 32'h0, 32'hA101_A100, 9};
    vt[11] = '{1'b0, 32'h0000_0400, 32'h0, 32'h1234_5678, 0};
    vt[12] = '{1'b0, 32'h0000_0800, 32'h0, 32'hCAFE_F00D, 9};
    vt[13] = '{1'b0, 32'h0000_0400, 32'h0, 32'h1234_5678, 0};
    vt[14] = '{1'b0, 32'h0000_0600, 32'h0, 32'hA101_A100, 9};
    vt[15] = '{1'b0, 32'h0000_0400, 32'h0, 32'h1234_5678, 0};
    vt[16] = '{1'b0, 32'h0000_0804, 32'h0, 32'hA203_A202, 9};
    vt[17] = '{1'b0, 32'h0008_03FC, 32'h0, 32'hAFFF_AFFE, 9};
    vt[18] = '{1'b0, 32'h0000_03FC, 32'h0, 32'hAFFF_AFFE, 0};
    vt[19] = '{1'b0, 32'h0008_03F8, 32'h0, 32'hAFFD_AFFC, 0};
    vt[20] = '{1'b0, 32'h0000_0400, 32'h0, 32'h1234_5678, 0};

    exp_fill_addr = '{18'd0, 18'd0, 18'd0, 18'd1, 18'd1, 18'd2, 18'd2, 18'd3, 18'd3};
    exp_wr_addr   = '{18'd0, 18'd0, 18'd1, 18'd1};
    exp_wr_we     = '{1'b0, 1'b1, 1'b0, 1'b1};

    // ---- reset state ----
    do_reset();
    @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_we_n", 32'(sram_we_n), 32'd1);
    check("reset_addr", 32'(sram_addr), 32'd0);
    @(posedge clk);
    #1;

    // ---- first miss: fill address sequence and strobe ----
    do_req(1'b0, 32'h400, 32'h0, rd, low);
    check("fill_rdata", rd, 32'hA001_A000);
    check("fill_stall", 32'(low), 32'd9);
    all_we_high = 1;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("fill_addr[%0d]", i), 32'(trace_addr[i]), 32'(exp_fill_addr[i]));
      if (!trace_we[i]) all_we_high = 0;
    end
    check("fill_we_n_high", 32'(all_we_high), 32'd1);
    do_req(1'b0, 32'h400, 32'h0, rd, low);
    check("repeat_hit_rdata", rd, 32'hA001_A000);
    check("repeat_hit_stall", 32'(low), 32'd0);

    // ---- store hit: bus pattern and cache update ----
    do_req(1'b1, 32'h400, 32'h1234_5678, rd, low);
    check("store_stall", 32'(low), 32'd5);
    check("store_idle_we_n", 32'(trace_we[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("store_we_n[%0d]", i), 32'(trace_we[i+1]), 32'(exp_wr_we[i]));
      check($sformatf("store_addr[%0d]", i), 32'(trace_addr[i+1]), 32'(exp_wr_addr[i]));
    end
    check("store_dq_lo", 32'(trace_dq[1]), 32'h5678);
    check("store_dq_hi", 32'(trace_dq[3]), 32'h1234);
    check("sram_hw0", 32'(sram_mem[0]), 32'h5678);
    check("sram_hw1", 32'(sram_mem[1]), 32'h1234);
    do_req(1'b0, 32'h400, 32'h0, rd, low);
    check("store_hit_rdata", rd, 32'h1234_5678);
    check("store_hit_stall", 32'(low), 32'd0);

    // ---- reset in the 3rd FILL cycle ----
    do_reset();
    @(posedge clk);
    #1;
    address  = 32'h400;
    mem_r_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    mem_r_en = 1'b0;
    @(negedge clk);
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_addr", 32'(sram_addr), 32'd0);
    @(posedge clk);
    #1;
    do_req(1'b0, 32'h400, 32'h0, rd, low);
    check("abort_reload_stall", 32'(low), 32'd9);
    check("abort_reload_rdata", rd, 32'hA001_A000);

    // ---- table: hits, write-through, eviction order, index wrap ----
    do_reset();
    @(posedge clk);
    #1;
    for (int v = 0; v < 21; v++) begin
      do_req(vt[v].wr, vt[v].addr, vt[v].wd, rd, low);
      if (!vt[v].wr) check($sformatf("vec%0d_rdata", v), rd, vt[v].exp_rd);
      check($sformatf("vec%0d_stall", v), 32'(low), 32'(vt[v].exp_low));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_cache_ctrl.md
# sram_cache_ctrl

Parametrised 2-way set-associative read cache in front of the 16-bit external SRAM. It replaces the direct SRAM controller between the EXE/MEM pipeline register and the SRAM pins. It serves 32-bit loads from on-chip line storage with no added latency on hits and fills 64-bit lines on misses. Stores are write-through with no write-allocate. `ready` low freezes the pipeline exactly as SRAM_READY did.

## Interface
- SETS, 64: sets per way; power of two, 2..256.
- WAIT_CYCLES, 2: cycles per SRAM halfword access; minimum 2.
- BASE_ADDR, 1024: CPU byte address that maps to SRAM halfword 0.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- mem_r_en  input  1  load request; held until the cycle `ready`=1.
- mem_w_en  input  1  store request; held until the cycle `ready`=1.
- address  input  32  CPU byte address (ALU result); bits [1:0] ignored.
- wdata  input  32  store data (Val_Rm).
- rdata  output  32  load data; valid when `ready`=1 with `mem_r_en`=1.
- ready  output  1  0 = freeze pipeline.
- SRAM_DQ  inout  16  data bus; driven only while the controller is writing, else high-Z.
- SRAM_ADDR  output  18  halfword address.
- SRAM_WE_N  output  1  write strobe, active-low.
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  output  1 each  constant 0.

## Operation
- Address split:
  - word = (address − BASE_ADDR)[18:2], 17 bits, modulo arithmetic.
  - offset = word[0].
  - index = word[log2(SETS):1].
  - tag = remaining upper word bits.
  - Line base halfword = {word[16:1], 2'b00}.
- Per set: two ways, each holding valid, tag and 2×32-bit data, plus one LRU bit. The LRU bit names the way to evict next.
- Halfword order within a word: low half at the even SRAM address.
- FSM states: IDLE, FILL, WRITE, DONE.
- IDLE behaviour:
  - No request: `ready`=1.
  - mem_w_en (priority over mem_r_en if both are high): `ready`=0; go to WRITE.
  - mem_r_en hit: `ready`=1; `rdata` = the hit word, combinational; LRU ← the other way; stay in IDLE.
  - mem_r_en miss: `ready`=0; pick the victim (invalid way0, else invalid way1, else the LRU way); go to FILL.
- FILL:
  - Four halfword windows at line base +0..+3, each lasting WAIT_CYCLES cycles.
  - SRAM_WE_N=1 throughout.
  - DQ is sampled on the last cycle of each window into the victim line.
  - After the 4th window: victim valid=1, tag written, LRU ← the other way; go to DONE.
- WRITE:
  - Two halfword windows at {word,0} and {word,1}. Data is wdata[15:0], then wdata[31:16].
  - DQ is driven for the whole window.
  - SRAM_WE_N=0 in every cycle of the window except its last; the address only changes while WE_N=1.
  - On a write hit, the cached word is updated when entering DONE; LRU is unchanged.
  - On a write miss, the cache is untouched.
- DONE:
  - `ready`=1.
  - For a read, `rdata` = the requested word from the just-filled line.
  - Request inputs are not re-evaluated this cycle; next state is IDLE.
- Requests must stay stable while `ready`=0; behaviour under a changing request is undefined.

## Timing
- Reset (rst high at an edge), from the next cycle:
  - state IDLE; all valid bits 0; all LRU bits 0; window counters 0.
  - SRAM_WE_N=1; SRAM_ADDR=0; DQ high-Z.
  - `ready`=1 while no request is present.
- Reset mid-FILL or mid-WRITE aborts immediately; a partial line is never marked valid.
- Read hit: `ready` never drops; zero added cycles.
- Read miss: `ready`=0 for 1+4·WAIT_CYCLES cycles, then `ready`=1 for one cycle (DONE). This is 9 low cycles at default.
- Store: `ready`=0 for 1+2·WAIT_CYCLES cycles, then DONE. This is 5 low cycles at default.
- Back-to-back requests: a new request in the cycle after DONE is handled normally from IDLE.
- Index wrap: the maximum word address maps to the last set; there is no aliasing beyond the tag.

## Test plan
- Reset, then load 0x400 → `ready` low 9 cycles; SRAM_ADDR sequence 0,1,2,3, each held 2 cycles; `rdata`={DQ@1,DQ@0}. A repeat load 0x400 → `ready` stays 1 with the same data.
- Load 0x404 right after the fill of 0x400 → hit with no stall; `rdata`={halfword3,halfword2}.
- Store 0x12345678 to 0x400 (cached) → SRAM writes 0x5678@0 then 0x1234@1, with WE_N pattern 0,1,0,1; `ready` low 5 cycles. Load 0x400 → hit returns 0x12345678.
- Store to an uncached 0x800 → SRAM written, cache unchanged. Load 0x800 → miss (9-cycle stall).
- SETS=64: loads of A, B and C, all with index 0 and distinct tags, then A again (hit), then C evicts B. Load of B → miss; load of A → hit.
- Assert rst in the 3rd cycle of a FILL → next cycle SRAM_WE_N=1 and state IDLE. Reload of the same address → full 9-cycle miss.
